mpres_prog: RTL
===============

MPRES_PROG -- requirements
Module: mpres_prog

Interface
REQ-001 SHALL have parameter NCH, default 4: number of output channels, 1..16.
REQ-002 SHALL have parameter N0, default 1: base prescaler width in bits, >=1; base tick every 2^N0 clk_in cycles.
REQ-003 SHALL have parameter W, default 8: per-channel divisor and counter width.
REQ-004 SHALL have parameter DIV_RST, default 0: divisor loaded into every channel at reset.
REQ-005 SHALL have port clk_in  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port ena  input  1  base prescaler count enable.
REQ-008 SHALL have port load  input  1  single-cycle divisor write strobe.
REQ-009 SHALL have port sel  input  4  channel index for load.
REQ-010 SHALL have port div  input  W  divisor value for load.
REQ-011 SHALL have port mode  input  1  channel mode for load: 0 = square, 1 = pulse.
REQ-012 SHALL have port D  output  NCH  channel outputs, registered.
REQ-013 SHALL have port tick  output  NCH  per-channel one-cycle tick strobes, registered.

Function
REQ-014 SHALL free-run the N0-bit base counter bcnt while ena=1, wrapping from 2^N0-1 to 0, and hold it while ena=0.
REQ-015 SHALL assert internal base_tick combinationally when ena=1 and bcnt=2^N0-1.
REQ-016 SHALL give each channel i registers div_i (W), mode_i (1), cnt_i (W).
REQ-017 SHALL, on a clk_in edge with base_tick=1 and cnt_i>=div_i, set cnt_i to 0 and tick_i to 1 for exactly the next cycle.
REQ-018 SHALL, on a base_tick edge with cnt_i<div_i, increment cnt_i; tick_i is 0 on every edge without a terminal count.
REQ-019 SHALL, in square mode (mode_i=0), toggle D_i on each tick_i event: D period = 2*(div_i+1)*2^N0 clk_in cycles, 50% duty.
REQ-020 SHALL, in pulse mode (mode_i=1), drive D_i identical to tick_i.
REQ-021 SHALL, for div_i=0, tick on every base tick.
REQ-022 SHALL, when load=1 and sel<NCH, write div and mode into channel sel and clear cnt_sel, D_sel and tick_sel on that edge.
REQ-023 SHALL ignore load when sel>=NCH: no state change in any channel.
REQ-024 SHALL give load priority over a coincident base_tick for the selected channel only; other channels process the base tick normally.
REQ-025 SHALL accept loads while ena=0, and SHALL hold all channel counters and D outputs while ena=0.
REQ-026 SHALL derive no clocks: all channel logic uses clk_in with base_tick as clock enable.

Reset
REQ-027 SHALL, while rst=1, force bcnt=0, every cnt_i=0, D=0, tick=0, every div_i=DIV_RST and every mode_i=0, regardless of clk_in.
REQ-028 SHALL, on the first edge after rst falls with ena=1, increment bcnt from 0; reset mid-count SHALL discard partial counts with no glitch on D or tick.

Structure
REQ-029 SHALL keep mode encodings (MODE_SQUARE=0, MODE_PULSE=1) and the sel width constant in the shared include mpres_defs.vh.
REQ-030 SHALL implement one channel as sub-module mpres_chan (inputs: base_tick, ld, div, mode; outputs: D, tick), instantiated NCH times by generate.
REQ-031 SHALL size the implementation at 120-400 lines of RTL total.

Verification
REQ-032 SHALL check: N0=1, all channels DIV_RST=0 square, ena=1 after reset -> tick every 2 cycles, D period 4 cycles on all channels.
REQ-033 SHALL check: load sel=2 div=3 mode=0 -> D[2] high for 8 cycles, low for 8 cycles, first toggle 8 cycles after the load edge.
REQ-034 SHALL check: load sel=1 div=4 mode=1 -> D[1]=tick[1], one cycle high every 10 cycles; other channels undisturbed.
REQ-035 SHALL check: ena low for 7 cycles mid-period -> bcnt, cnt and D frozen; period resumes seamlessly, extended by exactly 7 cycles.
REQ-036 SHALL check: load sel=5 with NCH=4 -> no change on any channel; load coinciding with base_tick -> selected channel restarts from 0, no tick.
REQ-037 SHALL check: rst pulse between clock edges mid-count -> D, tick, and counters 0 immediately, asynchronously; div restored to DIV_RST.

Source files
------------

// File: rtl/mpres_prog_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mpres_prog_pkg
//  Purpose  : Shared constants and types for the programmable multi-channel
//             prescaler (channel mode encoding, channel-select width).
//  Revision : 1.0  initial release
// ============================================================================
package mpres_prog_pkg;

    // Width of the channel-select bus on the load interface
    localparam int c_SEL_W = 4;

    // Per-channel output mode
    typedef enum logic {
        MODE_SQUARE = 1'b0,   // D toggles on every terminal count
        MODE_PULSE  = 1'b1    // D follows the one-cycle tick strobe
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/mpres_chan.sv
`default_nettype none
// ============================================================================
//  Module   : mpres_chan
//  Purpose  : One prescaler channel. Counts base ticks up to its divisor and
//             emits a one-cycle tick on the terminal count; D is either a
//             50% square wave (toggles per tick) or a copy of the tick.
//  Ports    : clk_in     - clock (rising edge)
//             rst        - asynchronous active-high reset
//             base_tick  - clock enable from the shared base prescaler
//             ld         - write strobe for this channel (already decoded)
//             div, mode  - divisor / mode written on ld
//             D, tick    - registered channel outputs
//  Revision : 1.0  initial release
// ============================================================================
module mpres_chan
    import mpres_prog_pkg::*;
#(
    parameter int W       = 8,
    parameter int DIV_RST = 0
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         base_tick,
    input  logic         ld,
    input  logic [W-1:0] div,
    input  logic         mode,
    output logic         D,
    output logic         tick
);

    logic [W-1:0] r_div;
    logic [W-1:0] r_cnt;
    mode_e        r_mode;
    logic         r_d;
    logic         r_tick;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_div  <= W'(DIV_RST);
            r_mode <= MODE_SQUARE;
            r_cnt  <= '0;
            r_d    <= 1'b0;
            r_tick <= 1'b0;
        end else if (ld) begin
            // A write restarts the channel from a clean phase; it wins over a
            // coincident base tick so the new divisor starts counting from 0.
            r_div  <= div;
            r_mode <= mode_e'(mode);
            r_cnt  <= '0;
            r_d    <= 1'b0;
            r_tick <= 1'b0;
        end else if (base_tick) begin
            if (r_cnt >= r_div) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_d    <= (r_mode == MODE_PULSE) ? 1'b1 : ~r_d;
            end else begin
                r_cnt  <= r_cnt + W'(1);
                r_tick <= 1'b0;
                if (r_mode == MODE_PULSE) begin
                    r_d <= 1'b0;
                end
            end
        end else begin
            // No base tick: counter and square output hold, strobes drop
            r_tick <= 1'b0;
            if (r_mode == MODE_PULSE) begin
                r_d <= 1'b0;
            end
        end
    end

    assign D    = r_d;
    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/mpres_prog.sv
`default_nettype none
// ============================================================================
//  Module   : mpres_prog
//  Purpose  : Programmable multi-channel prescaler. A shared N0-bit base
//             counter produces a base tick every 2^N0 clk_in cycles; each of
//             NCH channels divides that by (div+1) and drives D / tick.
//  Ports    : clk_in  - sole clock
//             rst     - asynchronous active-high reset
//             ena     - base prescaler count enable (freezes all channels)
//             load    - one-cycle divisor write strobe
//             sel     - channel index for load (ignored when >= NCH)
//             div     - divisor for load
//             mode    - 0 = square, 1 = pulse
//             D       - channel outputs (registered)
//             tick    - per-channel one-cycle tick strobes (registered)
//  Revision : 1.0  initial release
// ============================================================================
module mpres_prog
    import mpres_prog_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int N0      = 1,
    parameter int W       = 8,
    parameter int DIV_RST = 0
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               ena,
    input  logic               load,
    input  logic [c_SEL_W-1:0] sel,
    input  logic [W-1:0]       div,
    input  logic               mode,
    output logic [NCH-1:0]     D,
    output logic [NCH-1:0]     tick
);

    logic [N0-1:0] r_bcnt;
    logic          w_base_tick;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_bcnt <= '0;
        end else if (ena) begin
            r_bcnt <= r_bcnt + N0'(1);
        end
    end

    // Base tick is an enable, not a clock: it is high during the last cycle of
    // each base period so the channels act on the same edge that wraps bcnt.
    assign w_base_tick = ena && (r_bcnt == {N0{1'b1}});

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            // Decoding against each valid index implicitly ignores sel >= NCH
            logic w_ld;
            assign w_ld = load && (sel == c_SEL_W'(i));

            mpres_chan #(
                .W       (W),
                .DIV_RST (DIV_RST)
            ) u_chan (
                .clk_in    (clk_in),
                .rst       (rst),
                .base_tick (w_base_tick),
                .ld        (w_ld),
                .div       (div),
                .mode      (mode),
                .D         (D[i]),
                .tick      (tick[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
